// File: rtl/lut_truth_table_sweeper_if.sv
// ----------------------------------------------------------------------------
// lut_truth_table_sweeper_if
//
// Valid/ready word stream carrying packed truth-table words out of the
// sweeper.
//
//   m_data   packed truth-table word (WORD_W bits)
//   m_valid  m_data is valid
//   m_ready  sink accepts the word
//   m_last   high with the final word of a sweep
//
// Modports: master (sweeper side), slave (sink side).
// ----------------------------------------------------------------------------
interface lut_truth_table_sweeper_if #(
    parameter int WORD_W = 32
) ();
    logic [WORD_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/lut_truth_table_sweeper.sv
// ----------------------------------------------------------------------------
// lut_truth_table_sweeper
//
// Sequential exerciser for one LUT neuron. Drives every input pattern
// 0..2^IN_BITS-1 onto lut_in, samples lut_out after LUT_LAT cycles, packs the
// samples LSB-first into WORD_W-bit words and streams them out.
//
// Ports:
//   clk      clock
//   rst      asynchronous, active-low reset
//   start    one-cycle sweep request, honoured only when idle
//   busy     high while sweeping / emitting
//   done     one-cycle pulse after the final word is accepted
//   lut_in   pattern driven to the neuron
//   lut_out  neuron response
//   m        packed word stream (master side)
// ----------------------------------------------------------------------------
module lut_truth_table_sweeper #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int WORD_W   = 32,
    parameter int LUT_LAT  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [IN_BITS-1:0]            lut_in,
    input  logic [OUT_BITS-1:0]           lut_out,
    lut_truth_table_sweeper_if.master     m
);

    localparam int S      = WORD_W / OUT_BITS;
    localparam int SLOT_W = (S > 1) ? $clog2(S) : 1;
    localparam int WAIT_W = (LUT_LAT > 0) ? $clog2(LUT_LAT + 1) : 1;
    localparam int ADDR_W = IN_BITS + 1;

    if (((WORD_W % OUT_BITS) != 0) || ((((2 ** IN_BITS) * OUT_BITS) % WORD_W) != 0)) begin : g_bad_params
        $error("lut_truth_table_sweeper: WORD_W must be a multiple of OUT_BITS and divide 2^IN_BITS*OUT_BITS");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr, addr_n;
    logic [WAIT_W-1:0]   wait_cnt, wait_n;
    logic [WORD_W-1:0]   pack, pack_n;
    logic [WORD_W-1:0]   data_r, data_n;
    logic                valid_r, last_r;
    logic [SLOT_W-1:0]   slot;

    // S is a power of two (it divides 2^IN_BITS), so the slot is simply the
    // low address bits.
    assign slot = SLOT_W'(addr % ADDR_W'(S));

    always_comb begin
        state_n = state;
        addr_n  = addr;
        wait_n  = wait_cnt;
        pack_n  = pack;
        data_n  = data_r;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SWEEP;
                    addr_n  = '0;
                    wait_n  = '0;
                    pack_n  = '0;
                end
            end
            SWEEP: begin
                if (wait_cnt != WAIT_W'(LUT_LAT)) begin
                    wait_n = wait_cnt + WAIT_W'(1);
                end else begin
                    wait_n = '0;
                    addr_n = addr + ADDR_W'(1);
                    pack_n[slot*OUT_BITS +: OUT_BITS] = lut_out;
                    if (slot == SLOT_W'(S - 1)) begin
                        data_n  = pack_n;
                        state_n = EMIT;
                    end
                end
            end
            EMIT: begin
                if (m.m_ready) begin
                    // addr's extra bit marks that every pattern has been captured.
                    if (addr[IN_BITS]) begin
                        state_n = DONE;
                    end else begin
                        state_n = SWEEP;
                        pack_n  = '0;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with
    // the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr     <= '0;
            wait_cnt <= '0;
            pack     <= '0;
            data_r   <= '0;
            valid_r  <= 1'b0;
            last_r   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            addr     <= addr_n;
            wait_cnt <= wait_n;
            pack     <= pack_n;
            data_r   <= data_n;
            valid_r  <= (state_n == EMIT);
            last_r   <= (state_n == EMIT) && addr_n[IN_BITS];
            busy     <= (state_n == SWEEP) || (state_n == EMIT);
            done     <= (state_n == DONE);
        end
    end

    // In EMIT lut_in already shows the next pattern, which gives a pipelined
    // neuron a head start without affecting the capture point.
    always_comb begin
        lut_in = '0;
        if (state != IDLE) begin
            lut_in = addr[IN_BITS-1:0];
        end
    end

    assign m.m_data  = data_r;
    assign m.m_valid = valid_r;
    assign m.m_last  = last_r;

endmodule

// File: tb/tb_lut_truth_table_sweeper.sv
module tb_lut_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, start_b, start_c;
    logic busy_a, busy_b, busy_c;
    logic done_a, done_b, done_c;
    logic [7:0] lut_in_a, lut_in_b;
    logic [3:0] lut_in_c;
    logic lut_out_a, lut_out_b;
    logic [1:0] lut_out_c;
    logic sel_ff;
    logic b_p1, b_p2;

    int checks = 0;
    int errors = 0;

    lut_truth_table_sweeper_if #(.WORD_W(32)) ifa ();
    lut_truth_table_sweeper_if #(.WORD_W(32)) ifb ();
    lut_truth_table_sweeper_if #(.WORD_W(8))  ifc ();

    lut_truth_table_sweeper #(.IN_BITS(8), .OUT_BITS(1), .WORD_W(32), .LUT_LAT(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .lut_in(lut_in_a), .lut_out(lut_out_a), .m(ifa.master)
    );

    lut_truth_table_sweeper #(.IN_BITS(8), .OUT_BITS(1), .WORD_W(32), .LUT_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .lut_in(lut_in_b), .lut_out(lut_out_b), .m(ifb.master)
    );

    lut_truth_table_sweeper #(.IN_BITS(4), .OUT_BITS(2), .WORD_W(8), .LUT_LAT(0)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
        .lut_in(lut_in_c), .lut_out(lut_out_c), .m(ifc.master)
    );

    // Neuron models
    assign lut_out_a = sel_ff ? (lut_in_a == 8'hFF) : lut_in_a[0];
    always @(posedge clk) begin
        b_p1 <= lut_in_b[1];
        b_p2 <= b_p1;
    end
    assign lut_out_b = b_p2;
    assign lut_out_c = lut_in_c[1:0];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One sweep on dut_a. stall_word: word index held off for 5 cycles (-1 none).
    // poke: pulse start while busy and in the done cycle. abort_words: assert
    // reset 10 cycles after this many words were accepted (-1 none).
    task automatic sweep_a(input logic [31:0] exp_w, input logic [31:0] exp_last_w,
                           input int stall_word, input bit poke, input int abort_words,
                           input int exp_done);
        int cyc;
        int nwords;
        int busy_cnt;
        int done_cyc;
        int stall_left;
        int abort_cnt;
        bit stalled;
        bit aborted;
        logic [31:0] snap_d;
        logic snap_l;
        logic [7:0] snap_in;
        nwords = 0; busy_cnt = 0; done_cyc = -1; stall_left = 0; abort_cnt = 0;
        stalled = 1'b0; aborted = 1'b0; snap_d = '0; snap_l = 1'b0; snap_in = '0;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        cyc = 1;
        chk("a_first_lut_in", lut_in_a, 8'h00);
        while (cyc < 400 && done_cyc < 0 && !aborted) begin
            if (busy_a) busy_cnt++;
            if (done_a) done_cyc = cyc;
            start_a = poke && (cyc == 33 || cyc == 100);
            if (stall_left > 0) begin
                chk("a_stall_valid", ifa.m_valid, 1'b1);
                chk("a_stall_data", ifa.m_data, snap_d);
                chk("a_stall_last", ifa.m_last, snap_l);
                chk("a_stall_lut_in", lut_in_a, snap_in);
                stall_left--;
                if (stall_left == 0) ifa.m_ready = 1'b1;
            end else if (ifa.m_valid && nwords == stall_word && !stalled) begin
                stalled = 1'b1;
                stall_left = 5;
                snap_d = ifa.m_data;
                snap_l = ifa.m_last;
                snap_in = lut_in_a;
                ifa.m_ready = 1'b0;
            end
            if (ifa.m_valid && ifa.m_ready) begin
                chk("a_word_data", ifa.m_data, (nwords == 7) ? exp_last_w : exp_w);
                chk("a_word_last", ifa.m_last, (nwords == 7));
                nwords++;
            end
            if (abort_words >= 0 && nwords == abort_words) begin
                abort_cnt++;
                if (abort_cnt == 10) begin
                    #2 rst = 1'b0;
                    #1;
                    chk("a_abort_busy", busy_a, 1'b0);
                    chk("a_abort_done", done_a, 1'b0);
                    chk("a_abort_valid", ifa.m_valid, 1'b0);
                    chk("a_abort_last", ifa.m_last, 1'b0);
                    chk("a_abort_data", ifa.m_data, 32'h0);
                    chk("a_abort_lut_in", lut_in_a, 8'h00);
                    aborted = 1'b1;
                end
            end
            if (!aborted && done_cyc < 0) begin
                tick;
                cyc++;
            end
        end
        start_a = 1'b0;
        if (!aborted) begin
            chk("a_done_cycle", done_cyc, exp_done);
            chk("a_busy_cycles", busy_cnt, exp_done - 1);
            chk("a_word_count", nwords, 8);
            if (poke) start_a = 1'b1;
            tick;
            start_a = 1'b0;
            chk("a_idle_busy", busy_a, 1'b0);
            tick;
            chk("a_idle_busy2", busy_a, 1'b0);
            chk("a_idle_lut_in", lut_in_a, 8'h00);
        end
    endtask

    initial begin
        rst = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        sel_ff = 1'b0;
        ifa.m_ready = 1'b1; ifb.m_ready = 1'b1; ifc.m_ready = 1'b1;
        #3;
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_valid", ifa.m_valid, 1'b0);
        chk("rst_last", ifa.m_last, 1'b0);
        chk("rst_data", ifa.m_data, 32'h0);
        chk("rst_lut_in", lut_in_a, 8'h00);
        @(negedge clk) rst = 1'b1;
        tick;
        tick;

        // f(x)=x[0]
        sel_ff = 1'b0;
        sweep_a(32'hAAAAAAAA, 32'hAAAAAAAA, -1, 1'b0, -1, 265);
        // f(x)=(x==FF)
        sel_ff = 1'b1;
        sweep_a(32'h00000000, 32'h80000000, -1, 1'b0, -1, 265);
        // backpressure on word 3
        sel_ff = 1'b0;
        sweep_a(32'hAAAAAAAA, 32'hAAAAAAAA, 3, 1'b0, -1, 270);
        // start while busy / in done cycle
        sweep_a(32'hAAAAAAAA, 32'hAAAAAAAA, -1, 1'b1, -1, 265);
        // reset mid-word 4, then a clean sweep
        sweep_a(32'hAAAAAAAA, 32'hAAAAAAAA, -1, 1'b0, 4, 0);
        @(negedge clk) rst = 1'b1;
        tick;
        tick;
        chk("a_post_rst_busy", busy_a, 1'b0);
        chk("a_post_rst_valid", ifa.m_valid, 1'b0);
        sweep_a(32'hAAAAAAAA, 32'hAAAAAAAA, -1, 1'b0, -1, 265);

        // LUT_LAT=2, two-stage neuron on x[1]
        begin
            int cyc;
            int nwords;
            int done_cyc;
            nwords = 0; done_cyc = -1;
            start_b = 1'b1;
            tick;
            start_b = 1'b0;
            cyc = 1;
            while (cyc < 900 && done_cyc < 0) begin
                if (cyc == 1) chk("b_lut_in_c1", lut_in_b, 8'h00);
                if (cyc == 2) chk("b_lut_in_c2", lut_in_b, 8'h00);
                if (cyc == 3) chk("b_lut_in_c3", lut_in_b, 8'h00);
                if (cyc == 4) chk("b_lut_in_c4", lut_in_b, 8'h01);
                if (cyc == 7) chk("b_lut_in_c7", lut_in_b, 8'h02);
                if (done_b) done_cyc = cyc;
                if (ifb.m_valid && ifb.m_ready) begin
                    chk("b_word_data", ifb.m_data, 32'hCCCCCCCC);
                    chk("b_word_last", ifb.m_last, (nwords == 7));
                    nwords++;
                end
                if (done_cyc < 0) begin
                    tick;
                    cyc++;
                end
            end
            chk("b_done_cycle", done_cyc, 8 * 97 + 1);
            chk("b_word_count", nwords, 8);
        end

        // IN_BITS=4, OUT_BITS=2, WORD_W=8, f(x)=x[1:0]
        begin
            int cyc;
            int nwords;
            int done_cyc;
            nwords = 0; done_cyc = -1;
            start_c = 1'b1;
            tick;
            start_c = 1'b0;
            cyc = 1;
            while (cyc < 100 && done_cyc < 0) begin
                if (done_c) done_cyc = cyc;
                if (ifc.m_valid && ifc.m_ready) begin
                    chk("c_word_data", ifc.m_data, 8'hE4);
                    chk("c_word_last", ifc.m_last, (nwords == 3));
                    nwords++;
                end
                if (done_cyc < 0) begin
                    tick;
                    cyc++;
                end
            end
            chk("c_done_cycle", done_cyc, 21);
            chk("c_word_count", nwords, 4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lut_truth_table_sweeper.md
Name: lut_truth_table_sweeper

Overview:
- Sequential exerciser for one LUT neuron: drives every input pattern 0..2^IN_BITS-1 onto the neuron's input bus and samples its output.
- Packs the sampled bits into WORD_W-bit words and streams them out over a valid/ready interface.
- Used for on-chip readback and self-test of synthesized neuron truth tables against the trained model.

Parameters:
- IN_BITS, 8: neuron input width; 2^IN_BITS patterns are swept.
- OUT_BITS, 1: neuron output width.
- WORD_W, 32: output stream word width. Legal values satisfy WORD_W % OUT_BITS == 0 and (2^IN_BITS*OUT_BITS) % WORD_W == 0; elaboration error otherwise.
- LUT_LAT, 0: neuron latency in cycles; 0 means combinational.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep; ignored unless idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final word is accepted.
- lut_in  out  IN_BITS  pattern driven to the neuron.
- lut_out  in  OUT_BITS  neuron response.
- m_data  out  WORD_W  packed truth-table word.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  sink accepts the word.
- m_last  out  1  high with the final word of a sweep.

Behaviour:
- Reset (async, rst=0):
  - State goes to IDLE.
  - busy, done, m_valid and m_last are 0.
  - lut_in, m_data, the address counter (IN_BITS+1 bits) and the wait counter are 0.
  - Reset mid-sweep aborts immediately; m_valid drops without handshake, and no partial word is emitted afterwards.
- States are IDLE, SWEEP, EMIT and DONE.
- IDLE:
  - lut_in = 0.
  - start=1 moves to SWEEP next cycle, with addr=0, wait=0 and the pack register cleared.
- SWEEP:
  - lut_in = addr[IN_BITS-1:0] and stays stable for LUT_LAT+1 cycles.
  - While wait < LUT_LAT, wait increments.
  - When wait == LUT_LAT, lut_out is captured into pack bits [(addr mod S)*OUT_BITS +: OUT_BITS], where S = WORD_W/OUT_BITS. Then wait <= 0 and addr increments.
  - If the captured slot is S-1, the full word (including this capture) is loaded into m_data and the state moves to EMIT.
- EMIT:
  - m_valid = 1.
  - m_last = 1 if addr == 2^IN_BITS, i.e. this is the final word.
  - m_data, m_last and lut_in hold stable while m_ready = 0.
  - On m_valid & m_ready: m_valid drops next cycle. The state goes to DONE if it was the last word, else back to SWEEP with pack cleared.
- DONE:
  - done = 1 for exactly one cycle, busy = 0 in that cycle, then IDLE.
- busy = 1 in SWEEP and EMIT.
- start asserted in SWEEP, EMIT or DONE is ignored and has no queued effect.
- Word order: address 0 lands in word 0 bit 0 (LSB-first). Total words per sweep = 2^IN_BITS*OUT_BITS/WORD_W (8 for defaults).
- Timing, with m_ready tied high: each word takes S*(LUT_LAT+1) SWEEP cycles plus 1 EMIT cycle.
- Address counter wrap is impossible: the extra counter bit terminates the sweep at 2^IN_BITS.
- All outputs are registered except lut_in, which is decoded from the registered addr and state.

Test Plan:
- Defaults, neuron model f(x)=x[0], m_ready=1. Start pulse → 8 words, all 0xAAAAAAAA; m_last only on word 8; done pulse 265 cycles after start (8×33 + 1); busy high for 264 cycles.
- Model f(x)=(x==8'hFF) → words 0-6 = 0x00000000, word 7 = 0x80000000 with m_last=1.
- Backpressure: hold m_ready=0 for 5 cycles while word 3 is valid → m_data, m_last and lut_in are unchanged in every stalled cycle; word order and count are still correct; done is delayed by 5 cycles.
- LUT_LAT=2, neuron modelled as a 2-stage register of x[1] → each lut_in value is held 3 cycles; every word = 0xCCCCCCCC; done 8×97+1 cycles after start.
- Assert rst=0 mid-word 4, and pulse start while busy in a separate run:
  - Reset → all outputs 0 in the same cycle as rst falls; a new start after release yields a clean 8-word sweep beginning at address 0.
  - Start while busy → ignored.
- IN_BITS=4, OUT_BITS=2, WORD_W=8, model f(x)=x[1:0] → 4 words, each 0xE4; m_last on word 4.
